// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: power-on clear sweep, then CPU / tape-loader sharing
// with a small write buffer that pre-empts the CPU only when it is full.
module ram_arbiter #(
  parameter int          AW         = 16,
  parameter logic [7:0]  CLEAR_VAL  = 8'hFF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic          clk_48,
  input  logic          reset,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_wait,
  output logic          cpu_rvalid,
  output logic [7:0]    cpu_dout,
  input  logic          tape_wr,
  input  logic [AW-1:0] tape_addr,
  input  logic [7:0]    tape_din,
  output logic          tape_full,
  output logic          tape_idle,
  output logic          tape_ovf,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  input  logic [7:0]    ram_q,
  output logic          clear_busy
);

  localparam int             PW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_addr;
  logic [AW-1:0]   fifo_addr [FIFO_DEPTH];
  logic [7:0]      fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic            cpu_grant, tape_grant;
  logic            rd_pend, tape_on_ram;

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = tape_wr && !fifo_full && !reset;
  assign pop        = tape_grant;

  assign tape_full  = fifo_full;
  assign tape_idle  = reset || (fifo_empty && !tape_on_ram);
  // Read data is only meaningful in the strobe cycle; zero otherwise.
  assign cpu_dout   = cpu_rvalid ? ram_q : 8'h00;

  // NOTE: reset here is synchronous, so it only appears inside the clocked block.
  always_ff @(posedge clk_48) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    cpu_wait   = 1'b1;
    clear_busy = 1'b1;
    cpu_grant  = 1'b0;
    tape_grant = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        if (clr_addr == '1) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        clear_busy = 1'b0;
        if (fifo_full && cpu_cs) begin
          tape_grant = 1'b1;
        end else if (cpu_cs) begin
          cpu_grant = 1'b1;
          cpu_wait  = 1'b0;
        end else begin
          cpu_wait   = 1'b0;
          tape_grant = !fifo_empty;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
    if (reset) begin
      cpu_wait   = 1'b1;
      clear_busy = 1'b1;
      cpu_grant  = 1'b0;
      tape_grant = 1'b0;
    end
  end

  // NOTE: the buffer storage carries no reset; count and pointers alone define validity.
  always_ff @(posedge clk_48) begin
    if (push) begin
      fifo_addr[wr_ptr] <= tape_addr;
      fifo_data[wr_ptr] <= tape_din;
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      clr_addr    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tape_ovf    <= 1'b0;
      rd_pend     <= 1'b0;
      cpu_rvalid  <= 1'b0;
      tape_on_ram <= 1'b0;
      ram_ce      <= 1'b0;
      ram_we      <= 1'b0;
      ram_a       <= '0;
      ram_d       <= '0;
    end else begin
      rd_pend     <= cpu_grant && !cpu_we;
      cpu_rvalid  <= rd_pend;
      tape_on_ram <= tape_grant;

      // A write arriving at a full buffer is lost even if a slot frees this cycle.
      if (tape_wr && fifo_full) tape_ovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (state == ST_CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
        ram_ce   <= 1'b1;
        ram_we   <= 1'b1;
        ram_a    <= clr_addr;
        ram_d    <= CLEAR_VAL;
      end else if (cpu_grant) begin
        ram_ce <= 1'b1;
        ram_we <= cpu_we;
        ram_a  <= cpu_addr;
        ram_d  <= cpu_din;
      end else if (tape_grant) begin
        ram_ce <= 1'b1;
        ram_we <= 1'b1;
        ram_a  <= fifo_addr[rd_ptr];
        ram_d  <= fifo_data[rd_ptr];
      end else begin
        ram_ce <= 1'b0;
        ram_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (AW=4): clear sweep, CPU access, tape buffer
// fill/overflow/streaming and reset during the sweep, against a registered RAM model.
module tb_ram_arbiter;

  localparam int AW = 4;

  logic          clk_48 = 1'b0;
  logic          reset;
  logic          cpu_cs, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_wait, cpu_rvalid;
  logic [7:0]    cpu_dout;
  logic          tape_wr;
  logic [AW-1:0] tape_addr;
  logic [7:0]    tape_din;
  logic          tape_full, tape_idle, tape_ovf;
  logic          ram_ce, ram_we;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_d;
  logic [7:0]    ram_q;
  logic          clear_busy;

  int checks   = 0;
  int failures = 0;

  ram_arbiter #(.AW(AW), .CLEAR_VAL(8'hFF), .FIFO_DEPTH(4)) dut (
    .clk_48(clk_48), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_wait(cpu_wait), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
    .tape_wr(tape_wr), .tape_addr(tape_addr), .tape_din(tape_din),
    .tape_full(tape_full), .tape_idle(tape_idle), .tape_ovf(tape_ovf),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q),
    .clear_busy(clear_busy)
  );

  always #5 clk_48 = ~clk_48;

  // Registered-read RAM model plus a log of every write that reaches it.
  logic [7:0]    mem [16];
  logic [AW-1:0] log_a [$];
  logic [7:0]    log_d [$];

  always @(posedge clk_48) begin
    if (ram_ce) begin
      if (ram_we) begin
        mem[ram_a] <= ram_d;
        log_a.push_back(ram_a);
        log_d.push_back(ram_d);
      end
      ram_q <= mem[ram_a];
    end
  end

  task automatic test_reset;
    reset = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    tape_wr = 1'b0; tape_addr = '0; tape_din = '0;
    repeat (2) @(negedge clk_48);
    tape_wr = 1'b1; tape_addr = 4'h9; tape_din = 8'hAA;
    #1;
    checks++; if (clear_busy !== 1'b1) begin failures++; $display("FAIL rst_clear_busy got=%b exp=1", clear_busy); end
    checks++; if (cpu_wait !== 1'b1) begin failures++; $display("FAIL rst_cpu_wait got=%b exp=1", cpu_wait); end
    checks++; if (tape_idle !== 1'b1) begin failures++; $display("FAIL rst_tape_idle got=%b exp=1", tape_idle); end
    checks++; if ({ram_ce, ram_we, ram_a, ram_d} !== 14'h0) begin failures++; $display("FAIL rst_ram got=%b/%b/%h/%h exp=0/0/0/00", ram_ce, ram_we, ram_a, ram_d); end
    checks++; if ({cpu_rvalid, cpu_dout, tape_ovf} !== 10'h0) begin failures++; $display("FAIL rst_cpu_out got=%b/%h/%b exp=0/00/0", cpu_rvalid, cpu_dout, tape_ovf); end
    @(negedge clk_48);
    tape_wr = 1'b0; reset = 1'b0;
    #1;
    checks++; if (tape_idle !== 1'b1) begin failures++; $display("FAIL rst_tape_wr_ignored tape_idle got=%b exp=1", tape_idle); end
    checks++; if (clear_busy !== 1'b1) begin failures++; $display("FAIL rst_cycle1_busy got=%b exp=1", clear_busy); end
  endtask

  task automatic test_clear_sweep;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_48); #1;
      checks++; if ({ram_ce, ram_we, ram_a, ram_d} !== {2'b11, 4'(k), 8'hFF}) begin failures++; $display("FAIL sweep_write k=%0d got=%b/%b/%h/%h exp=1/1/%h/ff", k, ram_ce, ram_we, ram_a, ram_d, k); end
      checks++; if (clear_busy !== (k != 15)) begin failures++; $display("FAIL sweep_busy k=%0d got=%b exp=%b", k, clear_busy, k != 15); end
      checks++; if (cpu_wait !== (k != 15)) begin failures++; $display("FAIL sweep_wait k=%0d got=%b exp=%b", k, cpu_wait, k != 15); end
      if (k == 5) begin
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h4; cpu_din = 8'hEE;
        #1;
        checks++; if (cpu_wait !== 1'b1) begin failures++; $display("FAIL sweep_wait_cs got=%b exp=1", cpu_wait); end
      end
      if (k == 6) cpu_cs = 1'b0;
    end
    @(negedge clk_48); #1;
    checks++; if ({ram_ce, ram_we} !== 2'b00) begin failures++; $display("FAIL run_idle got=%b%b exp=00", ram_ce, ram_we); end
    checks++; if (mem[4'h4] !== 8'hFF) begin failures++; $display("FAIL sweep_no_cpu_write got=%h exp=ff", mem[4'h4]); end
  endtask

  task automatic test_cpu_rw;
    log_a.delete(); log_d.delete();
    @(negedge clk_48);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h4; cpu_din = 8'h5A;
    #1;
    checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL cpu_wr_wait got=%b exp=0", cpu_wait); end
    @(negedge clk_48);
    checks++; if ({ram_ce, ram_we, ram_a, ram_d} !== {2'b11, 4'h4, 8'h5A}) begin failures++; $display("FAIL cpu_wr_ram got=%b/%b/%h/%h exp=1/1/4/5a", ram_ce, ram_we, ram_a, ram_d); end
    cpu_we = 1'b0;
    #1;
    checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL cpu_rd_wait got=%b exp=0", cpu_wait); end
    @(negedge clk_48);
    checks++; if ({ram_ce, ram_we, ram_a} !== {2'b10, 4'h4}) begin failures++; $display("FAIL cpu_rd_ram got=%b/%b/%h exp=1/0/4", ram_ce, ram_we, ram_a); end
    checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL cpu_wr_no_rvalid got=%b exp=0", cpu_rvalid); end
    cpu_cs = 1'b0;
    @(negedge clk_48);
    checks++; if ({cpu_rvalid, cpu_dout} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL cpu_rd_data got=%b/%h exp=1/5a", cpu_rvalid, cpu_dout); end
    @(negedge clk_48);
    checks++; if ({cpu_rvalid, cpu_dout} !== 9'h0) begin failures++; $display("FAIL cpu_rvalid_once got=%b/%h exp=0/00", cpu_rvalid, cpu_dout); end
  endtask

  task automatic test_tape_full;
    log_a.delete(); log_d.delete();
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_48);
      tape_wr = 1'b1; tape_addr = 4'(8 + i); tape_din = 8'(8'h10 + i);
      #1;
      checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL fill_wait i=%0d got=%b exp=0", i, cpu_wait); end
    end
    @(negedge clk_48);
    tape_wr = 1'b0;
    #1;
    checks++; if ({tape_full, cpu_wait} !== 2'b11) begin failures++; $display("FAIL full_tape_wins full/wait got=%b%b exp=11", tape_full, cpu_wait); end
    @(negedge clk_48); #1;
    checks++; if ({tape_full, cpu_wait} !== 2'b00) begin failures++; $display("FAIL full_cpu_back full/wait got=%b%b exp=00", tape_full, cpu_wait); end
    checks++; if ({ram_ce, ram_we, ram_a, ram_d} !== {2'b11, 4'h8, 8'h10}) begin failures++; $display("FAIL full_tape_ram got=%b/%b/%h/%h exp=1/1/8/10", ram_ce, ram_we, ram_a, ram_d); end
    @(negedge clk_48);
    checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL tape_no_rvalid got=%b exp=0", cpu_rvalid); end
    cpu_cs = 1'b0;
    repeat (5) @(negedge clk_48);
    checks++; if (log_a.size() != 4) begin failures++; $display("FAIL full_log_len got=%0d exp=4", log_a.size()); end
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      checks++; if ({log_a[i], log_d[i]} !== {4'(8 + i), 8'(8'h10 + i)}) begin failures++; $display("FAIL full_order i=%0d got=%h/%h exp=%h/%h", i, log_a[i], log_d[i], 8 + i, 8'h10 + i); end
    end
    checks++; if ({tape_ovf, tape_idle} !== 2'b01) begin failures++; $display("FAIL full_end ovf/idle got=%b%b exp=01", tape_ovf, tape_idle); end
  endtask

  task automatic test_overflow;
    log_a.delete(); log_d.delete();
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_48);
      tape_wr = 1'b1; tape_addr = 4'(i); tape_din = 8'(8'h20 + i);
    end
    @(negedge clk_48);
    tape_addr = 4'h6; tape_din = 8'h66;
    #1;
    checks++; if ({tape_full, tape_ovf} !== 2'b10) begin failures++; $display("FAIL ovf_pre full/ovf got=%b%b exp=10", tape_full, tape_ovf); end
    @(negedge clk_48);
    tape_wr = 1'b0; cpu_cs = 1'b0;
    #1;
    checks++; if ({tape_full, tape_ovf} !== 2'b01) begin failures++; $display("FAIL ovf_set full/ovf got=%b%b exp=01", tape_full, tape_ovf); end
    repeat (6) @(negedge clk_48);
    checks++; if (log_a.size() != 4) begin failures++; $display("FAIL ovf_log_len got=%0d exp=4", log_a.size()); end
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      checks++; if ({log_a[i], log_d[i]} !== {4'(i), 8'(8'h20 + i)}) begin failures++; $display("FAIL ovf_order i=%0d got=%h/%h exp=%h/%h", i, log_a[i], log_d[i], i, 8'h20 + i); end
    end
    checks++; if (tape_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", tape_ovf); end
  endtask

  task automatic test_stream;
    log_a.delete(); log_d.delete();
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h4;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_48);
      tape_wr = (i < 8); tape_addr = 4'(i); tape_din = 8'(8'h30 + i);
      if (i == 3) cpu_cs = 1'b0;
      #1;
      if (i >= 3) begin
        checks++; if ({tape_idle, tape_full, cpu_wait} !== 3'b000) begin failures++; $display("FAIL stream i=%0d idle/full/wait got=%b%b%b exp=000", i, tape_idle, tape_full, cpu_wait); end
      end
    end
    repeat (5) @(negedge clk_48);
    checks++; if (log_a.size() != 8) begin failures++; $display("FAIL stream_log_len got=%0d exp=8", log_a.size()); end
    for (int i = 0; i < 8 && i < log_a.size(); i++) begin
      checks++; if ({log_a[i], log_d[i]} !== {4'(i), 8'(8'h30 + i)}) begin failures++; $display("FAIL stream_order i=%0d got=%h/%h exp=%h/%h", i, log_a[i], log_d[i], i, 8'h30 + i); end
    end
    checks++; if (tape_idle !== 1'b1) begin failures++; $display("FAIL stream_idle_end got=%b exp=1", tape_idle); end
  endtask

  task automatic test_reset_mid_clear;
    @(negedge clk_48);
    reset = 1'b1;
    @(negedge clk_48);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_48);
      tape_wr = (k == 0 || k == 1); tape_addr = (k == 0) ? 4'hD : 4'hE; tape_din = (k == 0) ? 8'h77 : 8'h88;
    end
    #1;
    checks++; if ({tape_idle, clear_busy, ram_a} !== {2'b01, 4'h6}) begin failures++; $display("FAIL mid_clear idle/busy/a got=%b/%b/%h exp=0/1/6", tape_idle, clear_busy, ram_a); end
    reset = 1'b1;
    #1;
    checks++; if ({tape_idle, clear_busy, cpu_wait} !== 3'b111) begin failures++; $display("FAIL mid_reset idle/busy/wait got=%b%b%b exp=111", tape_idle, clear_busy, cpu_wait); end
    @(negedge clk_48);
    reset = 1'b0;
    log_a.delete(); log_d.delete();
    #1;
    checks++; if ({ram_ce, ram_a, tape_idle, tape_ovf} !== {1'b0, 4'h0, 2'b10}) begin failures++; $display("FAIL post_reset ce/a/idle/ovf got=%b/%h/%b/%b exp=0/0/1/0", ram_ce, ram_a, tape_idle, tape_ovf); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_48);
      checks++; if (ram_a !== 4'(k)) begin failures++; $display("FAIL resweep k=%0d got=%h exp=%h", k, ram_a, k); end
    end
    repeat (4) @(negedge clk_48);
    checks++; if (log_a.size() != 16) begin failures++; $display("FAIL resweep_log_len got=%0d exp=16", log_a.size()); end
    for (int i = 0; i < log_d.size(); i++) begin
      checks++; if (log_d[i] !== 8'hFF) begin failures++; $display("FAIL dropped_tape_written i=%0d got=%h/%h exp=ff", i, log_a[i], log_d[i]); end
    end
    checks++; if (mem[4'hD] !== 8'hFF || mem[4'hE] !== 8'hFF) begin failures++; $display("FAIL dropped_tape_mem got=%h/%h exp=ff/ff", mem[4'hD], mem[4'hE]); end
  endtask

  initial begin
    test_reset;
    test_clear_sweep;
    test_cpu_rw;
    test_tape_full;
    test_overflow;
    test_stream;
    test_reset_mid_clear;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
